aes_round_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_round_timer.sv | 60 ++++++
 rtl/aes_round_ctrl.sv | 125 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and helpers for the AES-128 round sequencer.
// Imported by the controller and its round timer.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int BLK_W      = 128;
  localparam int KEY_W      = 128;
  localparam int KIDX_W     = 4;

  localparam logic ED_ENC = 1'b1;
  localparam logic ED_DEC = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ARK0,
    RUN,
    DONE
  } ctrl_state_t;

  typedef logic [BLK_W-1:0] blk_t;

  // Decrypt walks the key schedule backwards from the last round key.
  function automatic logic [KIDX_W-1:0] key_sel(
    input logic              ed,
    input logic [KIDX_W-1:0] rnd,
    input logic [KIDX_W-1:0] last
  );
    return (ed == ED_ENC) ? rnd : last - rnd;
  endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Per-round cycle counter and round number for the AES round sequencer.
// clear loads round 1; run advances through each round's cycles.
module aes_round_timer
  import aes_pkg::*;
#(
  parameter int ROUND_CYCLES = 5,
  parameter int NUM_ROUNDS   = aes_pkg::NUM_ROUNDS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        run,
  output logic [3:0]  round,
  output logic        round_last,
  output logic        final_round
);

  localparam int CNT_W = $clog2(ROUND_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [3:0] RND_MAX = 4'(NUM_ROUNDS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       round_q;
  logic [3:0]       round_d;

  assign round       = round_q;
  assign round_last  = run && (cnt_q == CNT_MAX);
  assign final_round = (round_q == RND_MAX);

  always_comb begin
    cnt_d   = cnt_q;
    round_d = round_q;
    if (clear) begin
      cnt_d   = '0;
      round_d = 4'd1;
    end else if (run) begin
      if (cnt_q == CNT_MAX) begin
        // the last round holds here while the controller leaves RUN
        if (!final_round) begin
          cnt_d   = '0;
          round_d = round_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the column-serial AES-128 round datapath: initial AddRoundKey,
// rounds 1..NUM_ROUNDS with round-key fetch, valid/ready block in and out.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_CYCLES = 5,
  parameter int NUM_ROUNDS   = aes_pkg::NUM_ROUNDS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  input  logic             in_ed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic [3:0]       key_idx,
  input  logic [KEY_W-1:0] key_data,
  output logic [BLK_W-1:0] rd_din,
  output logic [3:0]       rd_rc,
  output logic             rd_ed,
  output logic             rd_en,
  output logic [KEY_W-1:0] rd_key,
  input  logic [BLK_W-1:0] rd_dout
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  ctrl_state_t fsm_q;
  ctrl_state_t fsm_d;
  blk_t        blk_q;
  blk_t        blk_d;
  logic        ed_q;
  logic        ed_d;
  logic [3:0]  kidx_q;
  logic [3:0]  kidx_d;

  logic        tmr_clear;
  logic        tmr_run;
  logic [3:0]  round;
  logic        round_last;
  logic        final_round;

  aes_round_timer #(
    .ROUND_CYCLES (ROUND_CYCLES),
    .NUM_ROUNDS   (NUM_ROUNDS)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .clear       (tmr_clear),
    .run         (tmr_run),
    .round       (round),
    .round_last  (round_last),
    .final_round (final_round)
  );

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign out_block = out_valid ? blk_q : '0;
  assign key_idx   = kidx_q;
  assign rd_din    = blk_q;
  assign rd_rc     = round;
  assign rd_ed     = ed_q;
  assign rd_en     = (fsm_q == RUN);
  assign rd_key    = key_data;

  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    ed_d      = ed_q;
    kidx_d    = kidx_q;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d  = in_block;
          ed_d   = in_ed;
          kidx_d = key_sel(in_ed, 4'd0, LAST);
          fsm_d  = ARK0;
        end
      end
      ARK0: begin
        blk_d     = blk_q ^ key_data;
        tmr_clear = 1'b1;
        kidx_d    = key_sel(ed_q, 4'd1, LAST);
        fsm_d     = RUN;
      end
      RUN: begin
        tmr_run = 1'b1;
        // din only moves here, which restarts the datapath's column count
        if (round_last) begin
          blk_d = rd_dout;
          if (final_round) begin
            fsm_d = DONE;
          end else begin
            kidx_d = key_sel(ed_q, round + 4'd1, LAST);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      ed_q   <= 1'b0;
      kidx_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      ed_q   <= ed_d;
      kidx_q <= kidx_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES key store, column-serial datapath stand-in
// and a whole-cipher reference model; FIPS-197 vectors plus random blocks.
module tb_aes_round_ctrl;

  localparam int RC = 5;
  localparam int NR = 10;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         in_ed;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic [127:0] rd_din;
  logic [3:0]   rd_rc;
  logic         rd_ed;
  logic         rd_en;
  logic [127:0] rd_key;
  logic [127:0] rd_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk  [11];

  always #5 CLK = ~CLK;

  aes_round_ctrl #(.ROUND_CYCLES(RC), .NUM_ROUNDS(NR)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_ed     (in_ed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .key_idx   (key_idx),
    .key_data  (key_data),
    .rd_din    (rd_din),
    .rd_rc     (rd_rc),
    .rd_ed     (rd_ed),
    .rd_en     (rd_en),
    .rd_key    (rd_key),
    .rd_dout   (rd_dout)
  );

  assign key_data = rk[key_idx];

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] by(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] b;
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
      end
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = b;
      isb[b] = 8'(x);
    end
  endtask

  function automatic logic [127:0] subshift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        int src;
        logic [7:0] v;
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        v = by(s, 4*src + r);
        o[127-8*(4*c+r) -: 8] = inv ? isb[v] : sb[v];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   cf [4];
    logic [127:0] o;
    if (inv) begin
      cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], by(s, 4*c + j));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Whole-block reference: FIPS-197 cipher and inverse cipher.
  function automatic logic [127:0] aes_ref(input logic [127:0] b, input bit enc);
    logic [127:0] s;
    if (enc) begin
      s = b ^ rk[0];
      for (int r = 1; r <= NR; r++) begin
        s = subshift(s, 1'b0);
        if (r < NR) s = mix(s, 1'b0);
        s = s ^ rk[r];
      end
    end else begin
      s = b ^ rk[NR];
      for (int r = NR - 1; r >= 0; r--) begin
        s = subshift(s, 1'b1) ^ rk[r];
        if (r > 0) s = mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  // ---------------- datapath stand-in ----------------
  // Result is only valid once din has been stable for 4 column cycles.
  logic [127:0] last_din = '0;
  int           age = 0;
  int           age_eff;

  always_comb begin
    logic [127:0] t;
    age_eff = (rd_din != last_din) ? 0 : age;
    rd_dout = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
    if (rd_en && age_eff >= 4) begin
      if (rd_ed) begin
        t = subshift(rd_din, 1'b0);
        if (rd_rc != 4'(NR)) t = mix(t, 1'b0);
        rd_dout = t ^ rd_key;
      end else begin
        t = subshift(rd_din, 1'b1) ^ rd_key;
        if (rd_rc != 4'(NR)) t = mix(t, 1'b1);
        rd_dout = t;
      end
    end
  end

  always @(posedge CLK) begin
    last_din <= rd_din;
    age      <= age_eff + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One block through the controller, checking timing, key and round sequencing.
  task automatic xfer(input logic [127:0] blk, input bit enc, input logic [127:0] want,
                      input int hold, input string tag);
    int n;
    int i;
    int erc;
    bit rc_ok, k_ok, en_ok, stab;
    logic [127:0] held;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_block = blk;
    in_ed    = enc;
    tick();
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    in_ed    = ~enc;
    chk({tag, "_ark0_kidx"}, 128'(key_idx), enc ? 128'd0 : 128'(NR));
    chk({tag, "_ark0_en"}, 128'(rd_en), 128'd0);
    n = 1;
    rc_ok = 1'b1;
    k_ok  = 1'b1;
    en_ok = 1'b1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
      if (!out_valid) begin
        i   = n - 2;
        erc = i / RC + 1;
        if (rd_rc !== 4'(erc)) rc_ok = 1'b0;
        if (key_idx !== (enc ? 4'(erc) : 4'(NR - erc))) k_ok = 1'b0;
        if (rd_en !== 1'b1) en_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, 128'(n), 128'(2 + NR * RC));
    chk({tag, "_rc_seq"}, 128'(rc_ok), 128'd1);
    chk({tag, "_kidx_seq"}, 128'(k_ok), 128'd1);
    chk({tag, "_en_run"}, 128'(en_ok), 128'd1);
    chk({tag, "_result"}, out_block, want);
    held = out_block;
    stab = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 3);
      in_block = ~blk;
      tick();
      if (out_block !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || rd_en !== 1'b0)
        stab = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable"}, 128'(stab), 128'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 128'({in_ready, out_valid}), 128'b10);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] b1, b2, key;
    bit enc;
    int n;

    RST       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    in_ed     = 1'b0;
    out_ready = 1'b0;
    init_sbox();
    expand(FKEY);
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_rd_en_ed", 128'({rd_en, rd_ed}), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_rd_din", rd_din, 128'd0);
    chk("rst_rc_kidx", 128'({rd_rc, key_idx}), 128'd0);
    RST = 1'b0;
    tick();

    xfer(FPT, 1'b1, FCT, 0, "c1_enc");
    xfer(FCT, 1'b0, FPT, 0, "c1_dec");
    xfer(FPT, 1'b1, FCT, 20, "bp_enc");

    // Reset in round 5, cycle 2
    in_valid = 1'b1;
    in_block = FPT;
    in_ed    = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 23; k++) tick();
    chk("mid_rc", 128'(rd_rc), 128'd5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_state", 128'({in_ready, out_valid, rd_en}), 128'b100);
    xfer(FPT, 1'b1, FCT, 0, "post_rst");

    // Back-to-back with out_ready held high
    b1 = {$urandom, $urandom, $urandom, $urandom};
    b2 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = b1;
    in_ed     = 1'b1;
    tick();
    in_block = b2;
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_first", out_block, aes_ref(b1, 1'b1));
    tick();
    chk("b2b_accept_next", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_ark0", 128'(in_ready), 128'd0);
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_latency", 128'(n), 128'(2 + NR * RC));
    chk("b2b_second", out_block, aes_ref(b2, 1'b1));
    tick();
    out_ready = 1'b0;

    // Random keys, blocks, modes and backpressure
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      b1  = {$urandom, $urandom, $urandom, $urandom};
      enc = 1'($urandom_range(0, 1));
      expand(key);
      xfer(b1, enc, aes_ref(b1, enc), int'($urandom_range(0, 6)), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
